usermem_responder: RTL
======================

// Module: usermem_responder
// PURPOSE
// - Memory-side responder for the CPU user-memory interface: services address/rw requests from the control unit and returns usermem_data.
// - Holds a 2^ADDR_W x 8 synchronous RAM with a req/ready handshake and configurable read latency.
// - A write to MAILBOX_ADDR raises the CPU interrupt line; it stays high until the CPU acknowledges it.
// PARAMETERS
// - ADDR_W        8      address width; RAM depth = 2**ADDR_W words of 8 bits
// - READ_LAT      1      extra wait cycles before read data is valid (0..7)
// - MAILBOX_ADDR  8'hFF  write to this address sets interrupt
// - PROT_BASE     8'hF0  lowest write-protected address (used only with USERMEM_WPROT_EN)
// PORTS
// - clk              in   1       system clock, rising edge
// - reset            in   1       synchronous, active-high reset
// - req              in   1       request strobe; sampled in IDLE only
// - rw               in   1       1 = write, 0 = read; sampled with req
// - usermem_address  in   ADDR_W  word address; sampled with req
// - wdata            in   8       write data; sampled with req
// - usermem_data     out  8       read data; valid while ready=1 on a read
// - ready            out  1       one-cycle completion pulse
// - interrupt        out  1       mailbox interrupt, level
// - irq_ack          in   1       clears interrupt
// - wr_fault         out  1       protected-write pulse (0 when macro is off)
// BEHAVIOUR
// - Reset values: usermem_data=8'h00, ready=0, interrupt=0, wr_fault=0, FSM=IDLE, wait counter=0. RAM contents are not cleared.
// - FSM states: IDLE, RWAIT, RDONE, WDONE.
// - IDLE: req=1 latches address, rw and wdata.
//   - Write: RAM written on that edge, then -> WDONE.
//   - Read: if READ_LAT=0 -> RDONE, else -> RWAIT with counter=READ_LAT-1.
// - RWAIT: counter decrements each cycle; when counter=0 -> RDONE.
// - RDONE: usermem_data=RAM[latched addr], ready=1 for exactly 1 cycle, -> IDLE.
// - WDONE: ready=1 for exactly 1 cycle, -> IDLE.
// - Latency, req edge to ready high:
//   - Read: READ_LAT+1 cycles.
//   - Write: 1 cycle.
// - Back-to-back: a new req is accepted in the IDLE cycle right after ready. req outside IDLE is ignored (not queued).
// - usermem_data holds its last read value between reads; it is not changed by writes.
// - Address is used modulo 2**ADDR_W; no out-of-range condition exists.
// - Read-after-write to the same address returns the new data.
// - Interrupt:
//   - A committed write to MAILBOX_ADDR sets interrupt on the next edge.
//   - irq_ack=1 clears it.
//   - Set and ack in the same cycle: set wins, interrupt stays 1.
//   - The mailbox word is ordinary RAM and reads back the written value.
// - Reset asserted mid-transaction aborts it: no ready pulse, and a write already committed in IDLE stays in RAM.
// CONFIGURATION
// - USERMEM_WPROT_EN defined:
//   - A write with address >= PROT_BASE does not modify RAM and does not set interrupt.
//   - Such a write still completes via WDONE with ready=1, and wr_fault=1 in that same cycle.
//   - If MAILBOX_ADDR >= PROT_BASE, the mailbox is protected.
// - USERMEM_WPROT_EN undefined: all addresses writable; wr_fault tied to 0.
// TESTING
// - Reset, then idle 5 cycles -> ready=0, interrupt=0, usermem_data=8'h00, wr_fault=0.
// - Write 8'hA5 @8'h10, then read @8'h10 with READ_LAT=1 -> write ready 1 cycle after req; read ready 2 cycles after req; usermem_data=8'hA5.
// - Write 8'h3C @8'hFF -> interrupt=1 next cycle; irq_ack pulse -> interrupt=0; second mailbox write in the same cycle as irq_ack -> interrupt remains 1.
// - req=1 held during RWAIT with another address -> ignored; exactly one ready pulse per accepted req.
// - reset asserted in RWAIT -> no ready pulse; a following read of the same address returns the correct data.
// - USERMEM_WPROT_EN: write 8'h77 @8'hF4 -> ready=1 and wr_fault=1 in the same cycle; read @8'hF4 returns the previous content. Without the macro the read returns 8'h77 and wr_fault stays 0.

Source files
------------

// File: rtl/usermem_responder.sv
// usermem_responder: synchronous 8-bit RAM responder with req/ready handshake and mailbox interrupt.
// Optional write protection above PROT_BASE is enabled by defining USERMEM_WPROT_EN.
`default_nettype none

module usermem_responder #(
  parameter int                ADDR_W       = 8,
  parameter int                READ_LAT     = 1,
  parameter logic [ADDR_W-1:0] MAILBOX_ADDR = 8'hFF,
  parameter logic [ADDR_W-1:0] PROT_BASE    = 8'hF0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] usermem_address,
  input  logic [7:0]        wdata,
  output logic [7:0]        usermem_data,
  output logic              ready,
  output logic              interrupt,
  input  logic              irq_ack,
  output logic              wr_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RWAIT = 2'd1,
    RDONE = 2'd2,
    WDONE = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        cnt;
  logic [7:0]        mem [2**ADDR_W];

  logic accept;
  logic wprot;
  logic commit_wr;

  assign accept = (state == IDLE) && req;

`ifdef USERMEM_WPROT_EN
  assign wprot = (usermem_address >= PROT_BASE);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_fault <= 1'b0;
    end else begin
      wr_fault <= accept && rw && wprot;
    end
  end
`else
  logic unused_prot;
  assign unused_prot = (usermem_address >= PROT_BASE);
  assign wprot       = 1'b0;
  assign wr_fault    = 1'b0;
`endif

  // The RAM write happens on the accepting edge, so an abort afterwards cannot undo it.
  assign commit_wr = accept && rw && !wprot && !reset;

  always_ff @(posedge clk) begin
    if (commit_wr) begin
      mem[usermem_address] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      cnt          <= 3'd0;
      ready        <= 1'b0;
      interrupt    <= 1'b0;
      usermem_data <= 8'h00;
    end else begin
      ready <= 1'b0;
      // Set is evaluated after ack so a simultaneous set wins.
      if (irq_ack) begin
        interrupt <= 1'b0;
      end
      if (commit_wr && (usermem_address == MAILBOX_ADDR)) begin
        interrupt <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (req) begin
            addr_q <= usermem_address;
            if (rw) begin
              state <= WDONE;
              ready <= 1'b1;
            end else if (READ_LAT == 0) begin
              state        <= RDONE;
              ready        <= 1'b1;
              usermem_data <= mem[usermem_address];
            end else begin
              state <= RWAIT;
              cnt   <= 3'(READ_LAT - 1);
            end
          end
        end
        RWAIT: begin
          if (cnt == 3'd0) begin
            state        <= RDONE;
            ready        <= 1'b1;
            usermem_data <= mem[addr_q];
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RDONE:   state <= IDLE;
        WDONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
